// File: rtl/hamming32_pkg.sv
// Shared constants and helpers for the 32-bit SECDED (26-bit payload) code.
// Used by both the encoder and the hamming_decoder32 receive path.
package hamming32_pkg;

    localparam int CODE_W = 32;
    localparam int DATA_W = 26;
    localparam int SYN_W  = 5;

    // Hamming position of data bit i (all non-power-of-two positions).
    localparam logic [SYN_W-1:0] DPOS [DATA_W] = '{
        5'd3,  5'd5,  5'd6,  5'd7,
        5'd9,  5'd10, 5'd11, 5'd12,
        5'd13, 5'd14, 5'd15, 5'd17,
        5'd18, 5'd19, 5'd20, 5'd21,
        5'd22, 5'd23, 5'd24, 5'd25,
        5'd26, 5'd27, 5'd28, 5'd29,
        5'd30, 5'd31
    };

    // Returns {overall parity, syndrome}.
    function automatic logic [SYN_W:0] syn_par(
        input logic [CODE_W-1:0] c
    );
        logic [SYN_W-1:0] s;
        s = '0;
        for (int i = 1; i < CODE_W; i++) begin
            if (c[i]) s = s ^ SYN_W'(i);
        end
        return {^c, s};
    endfunction

endpackage

// File: rtl/hamming32_correct.sv
// Combinational stage-2 decode: classify error, flip the faulty
// position and extract the 26-bit payload.
module hamming32_correct
    import hamming32_pkg::*;
(
    input  logic [CODE_W-1:0] raw,
    input  logic [SYN_W-1:0]  syn,
    input  logic              par,
    output logic [DATA_W-1:0] data,
    output logic              single,
    output logic              dbl,
    output logic [SYN_W-1:0]  pos
);

    logic flip_en;

    // Parity-only positions never reach the payload.
    logic unused_pbits;
    assign unused_pbits = ^{raw[0], raw[1], raw[2],
                            raw[4], raw[8], raw[16]};

    always_comb begin
        single  = 1'b0;
        dbl     = 1'b0;
        pos     = syn;
        flip_en = 1'b0;
        data    = '0;
        if (par) begin
            single  = 1'b1;
            flip_en = (syn != '0);
        end else if (syn != '0) begin
            dbl = 1'b1;
        end
        for (int i = 0; i < DATA_W; i++) begin
            data[i] = raw[DPOS[i]]
                    ^ (flip_en && (syn == DPOS[i]));
        end
    end

endmodule

// File: rtl/hamming_decoder32.sv
// Two-stage valid/ready SECDED decoder with saturating error counters.
// Optional sticky double-error flag: HAMMING_DEC_STICKY_IRQ_EN.
module hamming_decoder32
    import hamming32_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CODE_W-1:0] code_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] data_out,
    output logic              err_single,
    output logic              err_double,
    output logic [SYN_W-1:0]  err_pos,
    input  logic              clr_cnt,
    output logic [CNT_W-1:0]  corr_cnt,
    output logic [CNT_W-1:0]  dbl_cnt
`ifdef HAMMING_DEC_STICKY_IRQ_EN
    ,
    output logic              err_irq
`endif
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic              v1;
    logic [CODE_W-1:0] raw1;
    logic [SYN_W-1:0]  s1;
    logic              p1;
    logic              v2;

    logic              adv1;
    logic              adv2;
    logic              out_hs;

    logic [DATA_W-1:0] c_data;
    logic              c_single;
    logic              c_dbl;
    logic [SYN_W-1:0]  c_pos;

    assign adv2      = !v2 || out_ready;
    assign adv1      = !v1 || adv2;
    assign in_ready  = !reset && adv1;
    assign out_valid = v2;
    assign out_hs    = v2 && out_ready;

    hamming32_correct u_correct (
        .raw    (raw1),
        .syn    (s1),
        .par    (p1),
        .data   (c_data),
        .single (c_single),
        .dbl    (c_dbl),
        .pos    (c_pos)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            v1         <= 1'b0;
            raw1       <= '0;
            s1         <= '0;
            p1         <= 1'b0;
            v2         <= 1'b0;
            data_out   <= '0;
            err_single <= 1'b0;
            err_double <= 1'b0;
            err_pos    <= '0;
            corr_cnt   <= '0;
            dbl_cnt    <= '0;
        end else begin
            if (adv1) begin
                v1 <= in_valid;
                if (in_valid) begin
                    raw1     <= code_in;
                    {p1, s1} <= syn_par(code_in);
                end
            end
            if (adv2) begin
                v2 <= v1;
                if (v1) begin
                    data_out   <= c_data;
                    err_single <= c_single;
                    err_double <= c_dbl;
                    err_pos    <= c_pos;
                end
            end
            // Clear has priority over a coincident increment.
            if (clr_cnt) begin
                corr_cnt <= '0;
                dbl_cnt  <= '0;
            end else if (out_hs) begin
                if (err_single && corr_cnt != CNT_MAX)
                    corr_cnt <= corr_cnt + CNT_W'(1);
                if (err_double && dbl_cnt != CNT_MAX)
                    dbl_cnt <= dbl_cnt + CNT_W'(1);
            end
        end
    end

`ifdef HAMMING_DEC_STICKY_IRQ_EN
    always_ff @(posedge clock) begin
        if (reset || clr_cnt)
            err_irq <= 1'b0;
        else if (out_hs && err_double)
            err_irq <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_hamming_decoder32.sv
// Self-checking bench for hamming_decoder32 (default and CNT_W=2).
// Covers HAMMING_DEC_STICKY_IRQ_EN when that macro is defined.
module tb_hamming_decoder32;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic        clr_cnt = 1'b0;
    logic [31:0] code_in = '0;

    logic        in_ready, out_valid;
    logic [25:0] data_out;
    logic        err_single, err_double;
    logic [4:0]  err_pos;
    logic [15:0] corr_cnt, dbl_cnt;

    logic        s_in_ready, s_out_valid;
    logic [25:0] s_data;
    logic        s_single, s_double;
    logic [4:0]  s_pos;
    logic [1:0]  s_corr, s_dbl;

`ifdef HAMMING_DEC_STICKY_IRQ_EN
    logic        err_irq, s_irq;
`endif

    hamming_decoder32 #(.CNT_W(16)) u_dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .code_in    (code_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .data_out   (data_out),
        .err_single (err_single),
        .err_double (err_double),
        .err_pos    (err_pos),
        .clr_cnt    (clr_cnt),
        .corr_cnt   (corr_cnt),
        .dbl_cnt    (dbl_cnt)
`ifdef HAMMING_DEC_STICKY_IRQ_EN
        ,
        .err_irq    (err_irq)
`endif
    );

    hamming_decoder32 #(.CNT_W(2)) u_sat (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (s_in_ready),
        .code_in    (code_in),
        .out_valid  (s_out_valid),
        .out_ready  (out_ready),
        .data_out   (s_data),
        .err_single (s_single),
        .err_double (s_double),
        .err_pos    (s_pos),
        .clr_cnt    (clr_cnt),
        .corr_cnt   (s_corr),
        .dbl_cnt    (s_dbl)
`ifdef HAMMING_DEC_STICKY_IRQ_EN
        ,
        .err_irq    (s_irq)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [25:0] d;
        logic        s;
        logic        e2;
        logic [4:0]  pos;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    int   exp_corr = 0;
    int   exp_dbl = 0;
    logic exp_irq = 1'b0;
    exp_t q[$];

    function automatic logic [31:0] enc(input logic [25:0] d);
        logic [31:0] c;
        int k;
        c = '0;
        k = 0;
        for (int i = 1; i < 32; i++) begin
            if ((i & (i - 1)) != 0) begin
                c[i] = d[k];
                k++;
            end
        end
        for (int b = 1; b < 32; b = b * 2)
            for (int j = 1; j < 32; j++)
                if ((j & b) != 0 && j != b) c[b] = c[b] ^ c[j];
        c[0] = ^c[31:1];
        return c;
    endfunction

    function automatic exp_t model(input logic [31:0] c);
        exp_t e;
        logic [31:0] f;
        int syn, par, k;
        syn = 0;
        par = 0;
        for (int i = 0; i < 32; i++) begin
            if (c[i]) begin
                par = par ^ 1;
                syn = syn ^ i;
            end
        end
        f = c;
        if (par == 1 && syn != 0) f[syn] = ~f[syn];
        e.s   = (par == 1);
        e.e2  = (par == 0 && syn != 0);
        e.pos = 5'(syn);
        e.d   = '0;
        k = 0;
        for (int i = 1; i < 32; i++) begin
            if ((i & (i - 1)) != 0) begin
                e.d[k] = f[i];
                k++;
            end
        end
        return e;
    endfunction

    function automatic int sat3(input int x);
        return (x > 3) ? 3 : x;
    endfunction

    task automatic chk(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h",
                   tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic cnt_chk(input string tag);
        chk({tag, "_corr"}, corr_cnt, exp_corr);
        chk({tag, "_dbl"}, dbl_cnt, exp_dbl);
        chk({tag, "_scorr"}, s_corr, sat3(exp_corr));
        chk({tag, "_sdbl"}, s_dbl, sat3(exp_dbl));
`ifdef HAMMING_DEC_STICKY_IRQ_EN
        chk({tag, "_irq"}, err_irq, exp_irq);
`endif
    endtask

    task automatic send(input logic [31:0] c,
                        input logic clr_at_out);
        exp_t e;
        int n;
        e = model(c);
        in_valid = 1'b1;
        code_in  = c;
        #1;
        n = 0;
        while (!in_ready && n < 20) begin
            step();
            n++;
        end
        chk("in_ready_wait", in_ready, 1'b1);
        step();
        in_valid = 1'b0;
        chk("lat_stage1", out_valid, 1'b0);
        step();
        chk("lat_valid", out_valid, 1'b1);
        chk("data", data_out, e.d);
        chk("single", err_single, e.s);
        chk("double", err_double, e.e2);
        chk("pos", err_pos, e.pos);
        if (e.s) exp_corr++;
        if (e.e2) begin
            exp_dbl++;
            exp_irq = 1'b1;
        end
        clr_cnt = clr_at_out;
        if (clr_at_out) begin
            exp_corr = 0;
            exp_dbl  = 0;
            exp_irq  = 1'b0;
        end
        step();
        clr_cnt = 1'b0;
        chk("drained", out_valid, 1'b0);
        cnt_chk("cnt");
    endtask

    logic [31:0] words[8];
    logic [25:0] hd;
    logic        hs, he2;
    logic [4:0]  hp;
    logic        stall_prev;
    int          sent, got, cyc, a, b;
    exp_t        e;

    initial begin
        reset = 1'b1;
        step();
        step();
        step();
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_data", data_out, 26'h0);
        chk("rst_single", err_single, 1'b0);
        chk("rst_double", err_double, 1'b0);
        chk("rst_pos", err_pos, 5'h0);
        cnt_chk("rst");
        reset = 1'b0;
        step();
        chk("post_rst_ready", in_ready, 1'b1);

        send(32'h00000000, 1'b0);
        send(32'hFFFFFFFF, 1'b0);
        chk("ones_data", data_out, 26'h3FFFFFF);
        send(32'h00000020, 1'b0);
        chk("pos5_cnt", corr_cnt, 16'd1);
        send(32'h00000001, 1'b0);
        send(32'h00000028, 1'b0);
        chk("dbl_cnt_1", dbl_cnt, 16'd1);
        send(enc(26'($urandom)), 1'b0);

        clr_cnt = 1'b1;
        exp_corr = 0;
        exp_dbl  = 0;
        exp_irq  = 1'b0;
        step();
        clr_cnt = 1'b0;
        cnt_chk("clr");

        send(enc(26'($urandom)) ^ 32'h00000020, 1'b0);
        send(32'h00000020, 1'b1);
        chk("clr_wins", corr_cnt, 16'd0);

        for (int i = 0; i < 5; i++) begin
            a = $urandom_range(1, 31);
            send(enc(26'($urandom)) ^ (32'h1 << a), 1'b0);
        end
        chk("sat_corr", s_corr, 2'd3);
        chk("full_corr", corr_cnt, 16'd5);

        for (int i = 0; i < 8; i++) begin
            words[i] = enc(26'($urandom));
            a = $urandom_range(0, 31);
            b = (a + $urandom_range(1, 31)) % 32;
            if (i % 3 == 1) words[i] ^= (32'h1 << a);
            if (i % 3 == 2)
                words[i] ^= (32'h1 << a) | (32'h1 << b);
        end
        sent = 0;
        got = 0;
        cyc = 0;
        stall_prev = 1'b0;
        while (got < 8 && cyc < 200) begin
            in_valid  = (sent < 8);
            code_in   = (sent < 8) ? words[sent] : 32'h0;
            out_ready = (cyc % 2 == 0);
            #1;
            if (stall_prev) begin
                chk("stall_valid", out_valid, 1'b1);
                chk("stall_data", data_out, hd);
                chk("stall_flags", {err_single, err_double},
                    {hs, he2});
                chk("stall_pos", err_pos, hp);
            end
            stall_prev = out_valid && !out_ready;
            hd  = data_out;
            hs  = err_single;
            he2 = err_double;
            hp  = err_pos;
            if (in_valid && in_ready) begin
                q.push_back(model(words[sent]));
                sent++;
            end
            if (out_valid && out_ready) begin
                chk("stream_q", q.size() > 0, 1'b1);
                if (q.size() > 0) begin
                    e = q.pop_front();
                    chk("stream_data", data_out, e.d);
                    chk("stream_single", err_single, e.s);
                    chk("stream_double", err_double, e.e2);
                    chk("stream_pos", err_pos, e.pos);
                    if (e.s) exp_corr++;
                    if (e.e2) begin
                        exp_dbl++;
                        exp_irq = 1'b1;
                    end
                end
                got++;
            end
            @(posedge clock);
            #1;
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("stream_count", got, 8);
        chk("stream_left", q.size(), 0);
        step();
        chk("stream_idle", out_valid, 1'b0);
        cnt_chk("stream");

        out_ready = 1'b0;
        in_valid  = 1'b1;
        code_in   = enc(26'($urandom)) ^ 32'h00000100;
        step();
        code_in   = enc(26'($urandom)) ^ 32'h00000300;
        step();
        in_valid  = 1'b0;
        chk("mid_full", out_valid, 1'b1);
        reset     = 1'b1;
        out_ready = 1'b1;
        exp_corr  = 0;
        exp_dbl   = 0;
        exp_irq   = 1'b0;
        #1;
        chk("mid_rst_ready", in_ready, 1'b0);
        step();
        chk("mid_rst_valid", out_valid, 1'b0);
        cnt_chk("mid_rst");
        reset = 1'b0;
        step();
        chk("mid_post_ready", in_ready, 1'b1);
        chk("mid_post_valid", out_valid, 1'b0);
        cnt_chk("mid_post");
        send(32'h00000000, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
